// File: rtl/rv64i_pipe_core_pkg.sv
// Shared definitions for the rv64i_pipe_core slice: opcode, funct3 and funct7
// encodings, the ALU operation enum, per-stage control bundle and the four
// pipeline register structs. The struct datapath width is fixed by CORE_XLEN.
package rv64i_pipe_core_pkg;

    localparam int CORE_XLEN = 64;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;
    localparam logic [2:0] F3_LD_SD   = 3'b011;
    localparam logic [2:0] F3_BEQ     = 3'b000;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_SUB  = 7'b0100000;

    typedef enum logic [1:0] {
        ALU_ADD = 2'd0,
        ALU_SUB = 2'd1,
        ALU_AND = 2'd2,
        ALU_OR  = 2'd3
    } alu_op_e;

    typedef struct packed {
        logic reg_write;
        logic mem_read;
        logic mem_write;
        logic mem_to_reg;
        logic alu_src;
        logic branch;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '0;

    typedef struct packed {
        logic                 valid;
        logic [CORE_XLEN-1:0] pc;
        logic [31:0]          instr;
    } if_id_t;

    // halt marks a real (unflushed) all-zero word; it is kept outside ctrl so
    // the word still decodes as a NOP with every control bit clear.
    typedef struct packed {
        ctrl_t                ctrl;
        alu_op_e              alu_op;
        logic                 halt;
        logic [CORE_XLEN-1:0] pc;
        logic [CORE_XLEN-1:0] rs1_data;
        logic [CORE_XLEN-1:0] rs2_data;
        logic [CORE_XLEN-1:0] imm;
        logic [4:0]           rs1;
        logic [4:0]           rs2;
        logic [4:0]           rd;
    } id_ex_t;

    typedef struct packed {
        ctrl_t                ctrl;
        logic [CORE_XLEN-1:0] alu_result;
        logic [CORE_XLEN-1:0] store_data;
        logic [4:0]           rd;
    } ex_mem_t;

    typedef struct packed {
        ctrl_t                ctrl;
        logic [CORE_XLEN-1:0] alu_result;
        logic [CORE_XLEN-1:0] load_data;
        logic [4:0]           rd;
    } mem_wb_t;

    function automatic logic [CORE_XLEN-1:0] alu_compute(
        input alu_op_e              op,
        input logic [CORE_XLEN-1:0] a,
        input logic [CORE_XLEN-1:0] b
    );
        logic [CORE_XLEN-1:0] res;
        case (op)
            ALU_SUB: res = a - b;
            ALU_AND: res = a & b;
            ALU_OR:  res = a | b;
            default: res = a + b;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/rv64i_pipe_core_mem.sv
// Thin Harvard memory wrappers for rv64i_pipe_core. Neither array is reset.
// Depths are powers of two so truncating the word address wraps modulo depth.
//
// instruction_memory ports:
//   addr  word address (PC[..:2])
//   data  32-bit instruction, combinational
// The instruction array has no write port; its contents are preloaded
// externally before the core leaves reset.
module instruction_memory #(
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic [AW-1:0] addr,
    output logic [31:0]   data
);

    logic [31:0] memory [DEPTH];

    assign data = memory[addr];

endmodule

// data_memory ports:
//   clk      write clock
//   addr     word address (alu_result[..:3])
//   wr_en    store strobe, written on the rising edge
//   wr_data  64-bit store data
//   rd_data  64-bit combinational read data
module data_memory #(
    parameter int XLEN  = 64,
    parameter int DEPTH = 128,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic [AW-1:0]   addr,
    input  logic            wr_en,
    input  logic [XLEN-1:0] wr_data,
    output logic [XLEN-1:0] rd_data
);

    logic [XLEN-1:0] memory [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            memory[addr] <= wr_data;
        end
    end

    assign rd_data = memory[addr];

endmodule

// File: rtl/rv64i_pipe_core_reg_file.sv
// register_file: 32 x XLEN integer register file, two combinational read
// ports and one write port. x0 always reads zero and ignores writes; a read
// of the register being written in the same cycle returns the new data.
// Ports:
//   clk, reset              clock, asynchronous active-low reset (clears x0..x31)
//   rd_addr1/2, rd_data1/2  read ports
//   wr_en, wr_addr, wr_data write port, committed on the rising edge
module register_file #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [4:0]      rd_addr1,
    input  logic [4:0]      rd_addr2,
    output logic [XLEN-1:0] rd_data1,
    output logic [XLEN-1:0] rd_data2,
    input  logic            wr_en,
    input  logic [4:0]      wr_addr,
    input  logic [XLEN-1:0] wr_data
);

    logic [XLEN-1:0] registers [32];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) begin
                registers[i] <= '0;
            end
        end else if (wr_en && (wr_addr != 5'd0)) begin
            registers[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        if (rd_addr1 == 5'd0) begin
            rd_data1 = '0;
        end else if (wr_en && (wr_addr == rd_addr1)) begin
            rd_data1 = wr_data;
        end else begin
            rd_data1 = registers[rd_addr1];
        end
    end

    always_comb begin
        if (rd_addr2 == 5'd0) begin
            rd_data2 = '0;
        end else if (wr_en && (wr_addr == rd_addr2)) begin
            rd_data2 = wr_data;
        end else begin
            rd_data2 = registers[rd_addr2];
        end
    end

endmodule

// File: rtl/rv64i_pipe_core.sv
// rv64i_pipe_core: 5-stage in-order RV64 integer core (IF, ID, EX, MEM, WB)
// executing add, sub, and, or, addi, ld, sd and beq. Forwarding from EX/MEM
// (priority) and MEM/WB, one-cycle load-use stall, branches resolved in EX
// with a two-cycle flush. An unflushed all-zero word reaching EX/MEM sets the
// sticky end_program flag, after which the PC freezes and only bubbles issue.
// Ports:
//   clk          rising-edge system clock
//   reset        asynchronous active-low reset
//   end_program  sticky program-complete flag
module rv64i_pipe_core
    import rv64i_pipe_core_pkg::*;
#(
    parameter int XLEN       = CORE_XLEN,
    parameter int IMEM_DEPTH = 256,
    parameter int DMEM_DEPTH = 128
) (
    input  logic clk,
    input  logic reset,
    output logic end_program
);

    localparam int IMEM_AW = $clog2(IMEM_DEPTH);
    localparam int DMEM_AW = $clog2(DMEM_DEPTH);

    if_id_t  if_id;
    id_ex_t  id_ex;
    id_ex_t  id_ex_next;
    ex_mem_t ex_mem;
    mem_wb_t mem_wb;

    // IF
    logic [XLEN-1:0] pc_current;
    logic [31:0]     instruction;

    // ID
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd_id;
    logic [XLEN-1:0] reg_read_data1;
    logic [XLEN-1:0] reg_read_data2;
    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] imm_s;
    logic [XLEN-1:0] imm_b;
    logic [XLEN-1:0] imm_id;
    ctrl_t           ctrl_id;
    alu_op_e         alu_op_id;
    logic            uses_rs1;
    logic            uses_rs2;
    logic            halt_id;
    logic            branch;
    logic            mem_to_reg;
    logic            alu_src;
    logic            load_use_stall;

    // EX
    logic [XLEN-1:0] fwd_a;
    logic [XLEN-1:0] fwd_b;
    logic [XLEN-1:0] alu_b;
    logic [XLEN-1:0] alu_result;
    logic [XLEN-1:0] branch_target;
    logic            branch_taken;
    logic            halt_hold;

    // MEM
    logic            mem_read;
    logic            mem_write;
    logic [XLEN-1:0] mem_read_data;
    logic [XLEN-1:0] wb_load_data;

    // WB
    logic            reg_write;
    logic [4:0]      reg_rd;
    logic [XLEN-1:0] reg_write_data;

    // ---------------------------------------------------------------- IF
    instruction_memory #(.DEPTH(IMEM_DEPTH)) imem (
        .addr (pc_current[2 +: IMEM_AW]),
        .data (instruction)
    );

    // ---------------------------------------------------------------- ID
    assign opcode = if_id.instr[6:0];
    assign rd_id  = if_id.instr[11:7];
    assign funct3 = if_id.instr[14:12];
    assign rs1    = if_id.instr[19:15];
    assign rs2    = if_id.instr[24:20];
    assign funct7 = if_id.instr[31:25];

    assign imm_i = {{(XLEN-12){if_id.instr[31]}}, if_id.instr[31:20]};
    assign imm_s = {{(XLEN-12){if_id.instr[31]}}, if_id.instr[31:25], if_id.instr[11:7]};
    assign imm_b = {{(XLEN-13){if_id.instr[31]}}, if_id.instr[31], if_id.instr[7],
                    if_id.instr[30:25], if_id.instr[11:8], 1'b0};

    always_comb begin
        ctrl_id   = CTRL_NOP;
        alu_op_id = ALU_ADD;
        imm_id    = '0;
        uses_rs1  = 1'b0;
        uses_rs2  = 1'b0;
        if (if_id.valid) begin
            case (opcode)
                OP_R: begin
                    ctrl_id.reg_write = 1'b1;
                    uses_rs1          = 1'b1;
                    uses_rs2          = 1'b1;
                    if (funct3 == F3_ADD_SUB && funct7 == F7_BASE) begin
                        alu_op_id = ALU_ADD;
                    end else if (funct3 == F3_ADD_SUB && funct7 == F7_SUB) begin
                        alu_op_id = ALU_SUB;
                    end else if (funct3 == F3_AND && funct7 == F7_BASE) begin
                        alu_op_id = ALU_AND;
                    end else if (funct3 == F3_OR && funct7 == F7_BASE) begin
                        alu_op_id = ALU_OR;
                    end else begin
                        ctrl_id  = CTRL_NOP;
                        uses_rs1 = 1'b0;
                        uses_rs2 = 1'b0;
                    end
                end
                OP_IALU: begin
                    if (funct3 == F3_ADD_SUB) begin
                        ctrl_id.reg_write = 1'b1;
                        ctrl_id.alu_src   = 1'b1;
                        imm_id            = imm_i;
                        uses_rs1          = 1'b1;
                    end
                end
                OP_LOAD: begin
                    if (funct3 == F3_LD_SD) begin
                        ctrl_id.reg_write  = 1'b1;
                        ctrl_id.mem_read   = 1'b1;
                        ctrl_id.mem_to_reg = 1'b1;
                        ctrl_id.alu_src    = 1'b1;
                        imm_id             = imm_i;
                        uses_rs1           = 1'b1;
                    end
                end
                OP_STORE: begin
                    if (funct3 == F3_LD_SD) begin
                        ctrl_id.mem_write = 1'b1;
                        ctrl_id.alu_src   = 1'b1;
                        imm_id            = imm_s;
                        uses_rs1          = 1'b1;
                        uses_rs2          = 1'b1;
                    end
                end
                OP_BRANCH: begin
                    if (funct3 == F3_BEQ) begin
                        ctrl_id.branch = 1'b1;
                        imm_id         = imm_b;
                        uses_rs1       = 1'b1;
                        uses_rs2       = 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign halt_id    = if_id.valid && (if_id.instr == 32'h0);
    assign branch     = ctrl_id.branch;
    assign mem_to_reg = ctrl_id.mem_to_reg;
    assign alu_src    = ctrl_id.alu_src;

    register_file #(.XLEN(XLEN)) reg_file (
        .clk      (clk),
        .reset    (reset),
        .rd_addr1 (rs1),
        .rd_addr2 (rs2),
        .rd_data1 (reg_read_data1),
        .rd_data2 (reg_read_data2),
        .wr_en    (reg_write),
        .wr_addr  (reg_rd),
        .wr_data  (reg_write_data)
    );

    // Unused source/destination fields are zeroed so forwarding and hazard
    // compares never match on immediate bits that happen to look like a register.
    always_comb begin
        id_ex_next          = '0;
        id_ex_next.ctrl     = ctrl_id;
        id_ex_next.alu_op   = alu_op_id;
        id_ex_next.halt     = halt_id;
        id_ex_next.pc       = if_id.pc;
        id_ex_next.rs1_data = reg_read_data1;
        id_ex_next.rs2_data = reg_read_data2;
        id_ex_next.imm      = imm_id;
        id_ex_next.rs1      = uses_rs1 ? rs1 : 5'd0;
        id_ex_next.rs2      = uses_rs2 ? rs2 : 5'd0;
        id_ex_next.rd       = ctrl_id.reg_write ? rd_id : 5'd0;
    end

    assign load_use_stall = id_ex.ctrl.mem_read && (id_ex.rd != 5'd0) &&
                            ((uses_rs1 && (id_ex.rd == rs1)) ||
                             (uses_rs2 && (id_ex.rd == rs2)));

    // ---------------------------------------------------------------- EX
    always_comb begin
        if (ex_mem.ctrl.reg_write && (ex_mem.rd != 5'd0) && (ex_mem.rd == id_ex.rs1)) begin
            fwd_a = ex_mem.alu_result;
        end else if (mem_wb.ctrl.reg_write && (mem_wb.rd != 5'd0) && (mem_wb.rd == id_ex.rs1)) begin
            fwd_a = reg_write_data;
        end else begin
            fwd_a = id_ex.rs1_data;
        end
    end

    always_comb begin
        if (ex_mem.ctrl.reg_write && (ex_mem.rd != 5'd0) && (ex_mem.rd == id_ex.rs2)) begin
            fwd_b = ex_mem.alu_result;
        end else if (mem_wb.ctrl.reg_write && (mem_wb.rd != 5'd0) && (mem_wb.rd == id_ex.rs2)) begin
            fwd_b = reg_write_data;
        end else begin
            fwd_b = id_ex.rs2_data;
        end
    end

    assign alu_b         = id_ex.ctrl.alu_src ? id_ex.imm : fwd_b;
    assign alu_result    = alu_compute(id_ex.alu_op, fwd_a, alu_b);
    assign branch_taken  = id_ex.ctrl.branch && (fwd_a == fwd_b);
    assign branch_target = id_ex.pc + id_ex.imm;

    // Once the halt word is in EX nothing younger may reach EX/MEM.
    assign halt_hold = end_program || id_ex.halt;

    // ---------------------------------------------------------------- MEM
    assign mem_read  = ex_mem.ctrl.mem_read;
    assign mem_write = ex_mem.ctrl.mem_write;

    data_memory #(.XLEN(XLEN), .DEPTH(DMEM_DEPTH)) dmem (
        .clk     (clk),
        .addr    (ex_mem.alu_result[3 +: DMEM_AW]),
        .wr_en   (mem_write),
        .wr_data (ex_mem.store_data),
        .rd_data (mem_read_data)
    );

    assign wb_load_data = mem_read ? mem_read_data : '0;

    // ---------------------------------------------------------------- WB
    assign reg_write      = mem_wb.ctrl.reg_write;
    assign reg_rd         = mem_wb.rd;
    assign reg_write_data = mem_wb.ctrl.mem_to_reg ? mem_wb.load_data : mem_wb.alu_result;

    // ---------------------------------------------------------------- state
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_current  <= '0;
            if_id       <= '0;
            id_ex       <= '0;
            ex_mem      <= '0;
            mem_wb      <= '0;
            end_program <= 1'b0;
        end else begin
            if (!halt_hold) begin
                if (branch_taken) begin
                    pc_current <= branch_target;
                end else if (!load_use_stall) begin
                    pc_current <= pc_current + 64'd4;
                end
            end

            // Flush beats stall: a held instruction behind a taken branch dies.
            if (halt_hold || branch_taken) begin
                if_id <= '0;
            end else if (!load_use_stall) begin
                if_id <= '{valid: 1'b1, pc: pc_current, instr: instruction};
            end

            if (halt_hold || branch_taken || load_use_stall) begin
                id_ex <= '0;
            end else begin
                id_ex <= id_ex_next;
            end

            ex_mem <= '{ctrl: id_ex.ctrl, alu_result: alu_result,
                        store_data: fwd_b, rd: id_ex.rd};

            mem_wb <= '{ctrl: ex_mem.ctrl, alu_result: ex_mem.alu_result,
                        load_data: wb_load_data, rd: ex_mem.rd};

            if (id_ex.halt) begin
                end_program <= 1'b1;
            end
        end
    end

    logic unused_bits;
    assign unused_bits = ^{pc_current[1:0], pc_current[XLEN-1:IMEM_AW+2],
                           ex_mem.alu_result[2:0], ex_mem.alu_result[XLEN-1:DMEM_AW+3],
                           mem_wb.ctrl};

endmodule

// File: tb/tb_rv64i_pipe_core.sv
module tb_rv64i_pipe_core;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic end_program;

    rv64i_pipe_core #(.XLEN(64), .IMEM_DEPTH(256), .DMEM_DEPTH(128)) dut (
        .clk         (clk),
        .reset       (reset),
        .end_program (end_program)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  rd;
        logic [63:0] data;
    } wb_exp_t;

    wb_exp_t wb_q[$];
    wb_exp_t mon_e;
    int      n_checks = 0;
    int      n_pass   = 0;
    bit      mon_en   = 0;

    // Scoreboard consumer: every architectural write-back is popped in order.
    always @(negedge clk) begin
        if (mon_en && reset && dut.reg_write && (dut.reg_rd != 5'd0)) begin
            n_checks++;
            if (wb_q.size() == 0) begin
                $display("FAIL wb_extra: got x%0d=%h, expected no write", dut.reg_rd, dut.reg_write_data);
            end else begin
                mon_e = wb_q.pop_front();
                if (dut.reg_rd !== mon_e.rd || dut.reg_write_data !== mon_e.data)
                    $display("FAIL wb_write: got x%0d=%h, expected x%0d=%h",
                             dut.reg_rd, dut.reg_write_data, mon_e.rd, mon_e.data);
                else
                    n_pass++;
            end
        end
    end

    // ---------------------------------------------------------- encoders
    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [2:0] f3,
                                          input logic [4:0] rd, input logic [4:0] a, input logic [4:0] b);
        return {f7, b, a, f3, rd, 7'b0110011};
    endfunction
    function automatic logic [31:0] addi_i(input logic [4:0] rd, input logic [4:0] a, input logic [11:0] imm);
        return {imm, a, 3'b000, rd, 7'b0010011};
    endfunction
    function automatic logic [31:0] ld_i(input logic [4:0] rd, input logic [4:0] a, input logic [11:0] imm);
        return {imm, a, 3'b011, rd, 7'b0000011};
    endfunction
    function automatic logic [31:0] sd_i(input logic [4:0] src, input logic [4:0] a, input logic [11:0] imm);
        return {imm[11:5], src, a, 3'b011, imm[4:0], 7'b0100011};
    endfunction
    function automatic logic [31:0] beq_i(input logic [4:0] a, input logic [4:0] b, input logic [12:0] off);
        return {off[12], off[10:5], b, a, 3'b000, off[4:1], off[11], 7'b1100011};
    endfunction

    // ---------------------------------------------------------- helpers
    task automatic push_wb(input logic [4:0] rd, input logic [63:0] data);
        wb_exp_t e;
        e.rd   = rd;
        e.data = data;
        wb_q.push_back(e);
    endtask

    task automatic begin_test();
        reset  = 1'b0;
        mon_en = 0;
        wb_q.delete();
        @(negedge clk);
        for (int i = 0; i < 256; i++) dut.imem.memory[i] = 32'h0;
    endtask

    task automatic release_and_run(output bit done);
        done   = 0;
        mon_en = 1;
        reset  = 1'b1;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (end_program === 1'b1) begin
                done = 1;
                break;
            end
        end
        repeat (4) @(negedge clk);
        mon_en = 0;
    endtask

    function automatic int count_nonzero_except(input int a, input int b);
        int n = 0;
        for (int i = 0; i < 32; i++)
            if (i != a && i != b && dut.reg_file.registers[i] !== 64'h0) n++;
        return n;
    endfunction

    // ---------------------------------------------------------- tests
    task automatic test_reset();
        int nz;
        reset = 1'b0;
        @(negedge clk);
        n_checks++;
        if (dut.pc_current !== 64'h0) $display("FAIL reset_pc: got %h, expected 0", dut.pc_current);
        else n_pass++;
        n_checks++;
        if (end_program !== 1'b0) $display("FAIL reset_end: got %b, expected 0", end_program);
        else n_pass++;
        n_checks++;
        if (dut.reg_write !== 1'b0 || dut.mem_write !== 1'b0)
            $display("FAIL reset_bubble: got reg_write=%b mem_write=%b, expected 0 0", dut.reg_write, dut.mem_write);
        else n_pass++;
        nz = count_nonzero_except(-1, -1);
        n_checks++;
        if (nz !== 0) $display("FAIL reset_regs: got %0d nonzero registers, expected 0", nz);
        else n_pass++;
    endtask

    task automatic test_branch_flush();
        bit done;
        int nz;
        begin_test();
        dut.imem.memory[0] = beq_i(5'd0, 5'd0, 13'd8);
        dut.imem.memory[1] = addi_i(5'd6, 5'd0, 12'd3);
        dut.imem.memory[2] = addi_i(5'd5, 5'd0, 12'd4);
        push_wb(5'd5, 64'd4);
        release_and_run(done);
        n_checks++;
        if (done !== 1'b1) $display("FAIL branch_timeout: end_program=%b, expected 1", end_program);
        else n_pass++;
        n_checks++;
        if (wb_q.size() != 0) $display("FAIL branch_missing_wb: got %0d pending, expected 0", wb_q.size());
        else n_pass++;
        n_checks++;
        if (dut.reg_file.registers[5] !== 64'd4) $display("FAIL branch_x5: got %h, expected 4", dut.reg_file.registers[5]);
        else n_pass++;
        n_checks++;
        if (dut.reg_file.registers[6] !== 64'd0) $display("FAIL branch_x6: got %h, expected 0", dut.reg_file.registers[6]);
        else n_pass++;
        nz = count_nonzero_except(5, 5);
        n_checks++;
        if (nz !== 0) $display("FAIL branch_others: got %0d nonzero, expected 0", nz);
        else n_pass++;
        // halt word at 12; fetch has already advanced two words when it reaches EX
        n_checks++;
        if (dut.pc_current !== 64'd20) $display("FAIL branch_pc_freeze: got %h, expected 14", dut.pc_current);
        else n_pass++;
    endtask

    task automatic test_forwarding(input bit check_final);
        bit done;
        logic [63:0] a, b;
        a = 64'd5;
        b = 64'd7;
        begin_test();
        dut.imem.memory[0] = addi_i(5'd1, 5'd0, 12'd5);
        dut.imem.memory[1] = addi_i(5'd2, 5'd0, 12'd7);
        dut.imem.memory[2] = enc_r(7'b0000000, 3'b000, 5'd3, 5'd1, 5'd2);
        dut.imem.memory[3] = enc_r(7'b0100000, 3'b000, 5'd4, 5'd3, 5'd1);
        dut.imem.memory[4] = enc_r(7'b0000000, 3'b111, 5'd5, 5'd3, 5'd2);
        dut.imem.memory[5] = enc_r(7'b0000000, 3'b110, 5'd6, 5'd1, 5'd2);
        push_wb(5'd1, a);
        push_wb(5'd2, b);
        push_wb(5'd3, a + b);
        push_wb(5'd4, (a + b) - a);
        push_wb(5'd5, (a + b) & b);
        push_wb(5'd6, a | b);
        if (check_final) begin
            release_and_run(done);
            n_checks++;
            if (done !== 1'b1) $display("FAIL fwd_timeout: end_program=%b, expected 1", end_program);
            else n_pass++;
            n_checks++;
            if (wb_q.size() != 0) $display("FAIL fwd_missing_wb: got %0d pending, expected 0", wb_q.size());
            else n_pass++;
            n_checks++;
            if (dut.reg_file.registers[4] !== 64'd7) $display("FAIL fwd_x4: got %h, expected 7", dut.reg_file.registers[4]);
            else n_pass++;
            n_checks++;
            if (dut.reg_file.registers[5] !== 64'd4) $display("FAIL fwd_x5: got %h, expected 4", dut.reg_file.registers[5]);
            else n_pass++;
            n_checks++;
            if (dut.pc_current !== 64'd32) $display("FAIL fwd_pc_freeze: got %h, expected 20", dut.pc_current);
            else n_pass++;
        end
    endtask

    task automatic test_load_use();
        bit done;
        begin_test();
        dut.dmem.memory[2] = 64'h0;
        dut.imem.memory[0] = addi_i(5'd1, 5'd0, 12'd42);
        dut.imem.memory[1] = sd_i(5'd1, 5'd0, 12'd16);
        dut.imem.memory[2] = ld_i(5'd2, 5'd0, 12'd16);
        dut.imem.memory[3] = enc_r(7'b0000000, 3'b000, 5'd3, 5'd2, 5'd2);
        push_wb(5'd1, 64'd42);
        push_wb(5'd2, 64'd42);
        push_wb(5'd3, 64'd84);
        release_and_run(done);
        n_checks++;
        if (done !== 1'b1) $display("FAIL ldu_timeout: end_program=%b, expected 1", end_program);
        else n_pass++;
        n_checks++;
        if (wb_q.size() != 0) $display("FAIL ldu_missing_wb: got %0d pending, expected 0", wb_q.size());
        else n_pass++;
        n_checks++;
        if (dut.dmem.memory[2] !== 64'd42) $display("FAIL ldu_dmem2: got %h, expected 2a", dut.dmem.memory[2]);
        else n_pass++;
        n_checks++;
        if (dut.reg_file.registers[3] !== 64'd84) $display("FAIL ldu_x3: got %h, expected 54", dut.reg_file.registers[3]);
        else n_pass++;
    endtask

    task automatic test_not_taken();
        bit done;
        begin_test();
        dut.imem.memory[0] = addi_i(5'd1, 5'd0, 12'hFFF);
        dut.imem.memory[1] = beq_i(5'd1, 5'd0, 13'd8);
        dut.imem.memory[2] = addi_i(5'd2, 5'd0, 12'd9);
        push_wb(5'd1, {64{1'b1}});
        push_wb(5'd2, 64'd9);
        release_and_run(done);
        n_checks++;
        if (done !== 1'b1) $display("FAIL nt_timeout: end_program=%b, expected 1", end_program);
        else n_pass++;
        n_checks++;
        if (wb_q.size() != 0) $display("FAIL nt_missing_wb: got %0d pending, expected 0", wb_q.size());
        else n_pass++;
        n_checks++;
        if (dut.reg_file.registers[1] !== 64'hFFFF_FFFF_FFFF_FFFF)
            $display("FAIL nt_x1: got %h, expected ffffffffffffffff", dut.reg_file.registers[1]);
        else n_pass++;
    endtask

    task automatic test_x0();
        bit done;
        begin_test();
        dut.imem.memory[0] = addi_i(5'd0, 5'd0, 12'd5);
        dut.imem.memory[1] = enc_r(7'b0000000, 3'b000, 5'd1, 5'd0, 5'd0);
        push_wb(5'd1, 64'd0);
        release_and_run(done);
        n_checks++;
        if (done !== 1'b1) $display("FAIL x0_timeout: end_program=%b, expected 1", end_program);
        else n_pass++;
        n_checks++;
        if (wb_q.size() != 0) $display("FAIL x0_missing_wb: got %0d pending, expected 0", wb_q.size());
        else n_pass++;
        n_checks++;
        if (dut.reg_file.registers[0] !== 64'd0) $display("FAIL x0_value: got %h, expected 0", dut.reg_file.registers[0]);
        else n_pass++;
    endtask

    task automatic test_async_reset();
        bit done;
        test_forwarding(1'b0);
        wb_q.delete();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if (dut.pc_current !== 64'd12) $display("FAIL ares_pc_running: got %h, expected c", dut.pc_current);
        else n_pass++;
        #2 reset = 1'b0;
        #1;
        n_checks++;
        if (dut.pc_current !== 64'h0) $display("FAIL ares_pc_async: got %h, expected 0", dut.pc_current);
        else n_pass++;
        @(negedge clk);
        push_wb(5'd1, 64'd5);
        push_wb(5'd2, 64'd7);
        push_wb(5'd3, 64'd12);
        push_wb(5'd4, 64'd7);
        push_wb(5'd5, 64'd4);
        push_wb(5'd6, 64'd7);
        release_and_run(done);
        n_checks++;
        if (done !== 1'b1) $display("FAIL ares_rerun_timeout: end_program=%b, expected 1", end_program);
        else n_pass++;
        n_checks++;
        if (wb_q.size() != 0) $display("FAIL ares_missing_wb: got %0d pending, expected 0", wb_q.size());
        else n_pass++;
        n_checks++;
        if (dut.reg_file.registers[6] !== 64'd7) $display("FAIL ares_x6: got %h, expected 7", dut.reg_file.registers[6]);
        else n_pass++;
        #2 reset = 1'b0;
        #1;
        n_checks++;
        if (end_program !== 1'b0) $display("FAIL ares_end_async: got %b, expected 0", end_program);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_branch_flush();
        test_forwarding(1'b1);
        test_load_use();
        test_not_taken();
        test_x0();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/rv64i_pipe_core.md
Name: rv64i_pipe_core

Overview:
- 5-stage in-order pipelined RV64 integer core (IF, ID, EX, MEM, WB) with Harvard memories: instruction memory instance imem, data memory instance dmem, register file instance reg_file.
- Top-level CPU of the processor subsystem.
- Executes add, sub, and, or, addi, ld, sd and beq.
- Signals program completion on end_program.

Parameters:
- XLEN, 64, datapath and register width.
- IMEM_DEPTH, 256, instruction memory words (32-bit each).
- DMEM_DEPTH, 128, data memory words (64-bit each).

Ports:
- clk  input  1  rising-edge system clock.
- reset  input  1  asynchronous, active-low reset: core is held in reset while reset=0.
- end_program  output  1  sticky program-complete flag.

Behaviour:
- Reset, asynchronous, active while reset=0:
  - PC=0.
  - All pipeline registers become bubbles (all control bits 0).
  - Registers x0..x31 cleared to 0.
  - end_program=0.
  - imem and dmem are not reset; the bench preloads imem before releasing reset.
- Required hierarchical names, used by verification:
  - Arrays imem.memory[], dmem.memory[], reg_file.registers[].
  - Nets pc_current, instruction (IF stage).
  - Nets rs1, rs2, reg_read_data1, reg_read_data2 (ID stage).
  - Net alu_result (EX stage).
  - Nets mem_read, mem_write, mem_read_data (MEM stage).
  - Nets reg_write, reg_rd, reg_write_data (WB stage).
  - Control nets branch, mem_to_reg, alu_src.
- IF:
  - instruction = imem.memory[pc_current[..:2]].
  - Next PC is PC+4, or the branch target on redirect.
  - PC holds during a stall.
- ID:
  - Decode opcode, funct3 and funct7.
  - Immediates sign-extended to 64 bits in I, S and B formats (B immediate has bit 0 = 0).
  - All-zero word and unknown opcodes decode as NOP (all control bits 0).
- Register file:
  - x0 reads 0; writes to x0 are ignored.
  - Write on the clock edge; a same-cycle read of the register being written returns the new data (internal bypass).
- EX:
  - ALU: add; sub (funct7=0100000); and; or.
  - addi, ld and sd compute rs1+imm.
  - beq compares rs1==rs2 using forwarded operands.
  - Arithmetic wraps modulo 2^64.
- Forwarding:
  - EX/MEM result takes priority over MEM/WB result for each of rs1 and rs2.
  - Never forward when the producer's rd=0.
- Load-use hazard: if ID needs the rd of an ld currently in EX, stall IF/ID for 1 cycle and insert a bubble into EX.
- Branch:
  - Resolved in EX; target = branch PC + imm.
  - If taken, flush IF/ID and ID/EX (2-cycle penalty) and redirect the PC.
  - Not taken: no penalty.
  - A taken branch flushes any stall-held instruction in the same cycle (flush has priority over stall).
- MEM:
  - dmem is word-addressed by alu_result[..:3] with 64-bit entries.
  - sd writes on the clock edge.
  - ld reads combinationally; mem_read_data is latched into MEM/WB.
  - Out-of-range addresses wrap modulo depth.
- WB: reg_write_data = mem_to_reg ? load data : ALU result.
- end_program:
  - Sets to 1, sticky until reset, when an unflushed all-zero instruction is latched into EX/MEM.
  - After it sets, the PC freezes and no further instructions issue.
  - Older instructions drain within 2 cycles.
- Simultaneous events: a WB write and an ID read of the same register in one cycle yields the new value.

Decomposition:
- Shared package:
  - Opcode constants: R=0110011, I-ALU=0010011, LOAD=0000011, STORE=0100011, BRANCH=1100011.
  - funct3 and funct7 constants.
  - ALU-op enum.
  - Pipeline-register structs IF/ID, ID/EX, EX/MEM and MEM/WB.
- One natural sub-module: register_file, instantiated as reg_file (2 read ports, 1 write port).
- imem and dmem are thin memory wrappers named instruction_memory and data_memory.

Test Plan:
- Taken-branch flush:
  - Program: beq x0,x0,8; addi x6,x0,3; addi x5,x0,4; 0.
  - Required: x5=4, x6=0; end_program asserts; all other registers 0.
- Forwarding:
  - Program: addi x1,x0,5; addi x2,x0,7; add x3,x1,x2; sub x4,x3,x1; and x5,x3,x2; or x6,x1,x2; 0.
  - Required: x3=12, x4=7, x5=4, x6=7.
- Load-use stall:
  - Program: addi x1,x0,42; sd x1,16(x0); ld x2,16(x0); add x3,x2,x2; 0.
  - Required: dmem.memory[2]=42, x2=42, x3=84.
- Not-taken branch and negative immediate:
  - Program: addi x1,x0,-1; beq x1,x0,8; addi x2,x0,9; 0.
  - Required: x1=0xFFFFFFFFFFFFFFFF, x2=9.
- x0 immutability: addi x0,x0,5; add x1,x0,x0 -> x0=0, x1=0.
- Asynchronous reset mid-run: drive reset=0 during execution -> PC=0 and end_program=0 immediately, without waiting for a clock edge; after release the program re-executes from address 0.
